sar_result_reader: RTL

//  Consumer side of the SAR conversion interface: watches EOC, captures the

---
 rtl/sar_result_reader_if.sv | 18 +
 rtl/sar_result_reader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sar_result_reader_if.sv
// Result stream between the SAR result reader and the digital back-end.
//   m_valid : result available at the FIFO head
//   m_ready : consumer accepts the head result this cycle
//   m_data  : head result (averaged SAR code)
//   m_tag   : wrapping sequence tag of the head result
// master = producer (sar_result_reader), slave = consumer.
interface sar_result_reader_if #(
  parameter int DATA_W = 10,
  parameter int TAG_W  = 4
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [TAG_W-1:0]  m_tag;

  modport master (output m_valid, m_data, m_tag, input m_ready);
  modport slave  (input m_valid, m_data, m_tag, output m_ready);
endinterface

// File: rtl/sar_result_reader.sv
// sar_result_reader
// Consumer side of the SAR conversion interface. A rising EOC captures the
// SAR code, 2^AVG_LOG2 codes are averaged (truncating), and each result is
// tagged and queued in a show-ahead FIFO that drains over a valid/ready stream.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   eoc         : end-of-conversion level from the SAR logic
//   d_in        : SAR code, sampled on the edge where eoc rises
//   clr_ovf     : synchronous clear of the sticky overflow flag
//   m           : result stream (master modport: m_valid/m_data/m_tag out, m_ready in)
//   ovf         : sticky, a result was dropped because the FIFO was full
//   fifo_level  : number of results currently held
module sar_result_reader #(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int AVG_LOG2   = 0,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          eoc,
  input  logic [DATA_W-1:0]             d_in,
  input  logic                          clr_ovf,
  sar_result_reader_if.master           m,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ENT_W = DATA_W + TAG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

  // Average of 2^AVG_LOG2 codes; fractional part is discarded.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] shifted;
    shifted   = sum >> AVG_LOG2;
    avg_trunc = shifted[DATA_W-1:0];
  endfunction

  // ---- Stage p0: EOC edge detect and accumulation ----
  logic              eoc_q;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              cap_p0;
  logic              final_p0;
  logic              push_p0;
  logic [ACC_W-1:0]  sum_p0;
  logic [DATA_W-1:0] res_p0;

  assign cap_p0   = eoc & ~eoc_q;
  assign final_p0 = (cnt == CNT_MAX);
  assign push_p0  = cap_p0 & final_p0;
  assign sum_p0   = acc + ACC_W'(d_in);
  assign res_p0   = avg_trunc(sum_p0);

  // eoc_q resets high so an EOC already high when reset releases is not
  // mistaken for a fresh conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eoc_q <= 1'b1;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      eoc_q <= eoc;
      if (cap_p0) begin
        if (final_p0) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum_p0;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // ---- Stage p1: result FIFO ----
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [TAG_W-1:0] tag_cnt;
  logic             vld_p1;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign vld_p1 = (level != '0);
  assign full   = (level == LVL_W'(FIFO_DEPTH));
  assign pop    = vld_p1 & m.m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en  = push_p0 & (~full | pop);
  assign drop   = push_p0 & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {res_p0, tag_cnt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      tag_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(wr_en) - LVL_W'(pop);
      // Tag advances even on a drop so the consumer can detect the loss.
      if (push_p0) tag_cnt <= tag_cnt + 1'b1;
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // ---- Stage p2: show-ahead output ----
  // Outputs are forced to zero when empty so the un-reset storage never
  // shows through, including immediately after reset.
  assign m.m_valid  = vld_p1;
  assign m.m_data   = vld_p1 ? mem[rd_ptr][ENT_W-1:TAG_W] : '0;
  assign m.m_tag    = vld_p1 ? mem[rd_ptr][TAG_W-1:0]     : '0;
  assign fifo_level = level;
endmodule
